sparse_lif_array: RTL and testbench
===================================

SPARSE_LIF_ARRAY -- requirements
Module: sparse_lif_array

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_NEUR, 4, neuron count (power of two, >=2); CW = log2(N_NEUR)
- W, 8, membrane/current width, unsigned
- THRESHOLD, 200, fire threshold (1..2^W-1)
- LEAK_SHIFT, 1, leak = state >> LEAK_SHIFT
- REFRAC, 2, refractory steps after a spike (0..15)

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  current sample offered
- in_ready  out  1  sample accepted when in_valid&&in_ready
- in_ch  in  CW  target neuron index
- in_current  in  W  input current, unsigned
- step  in  1  timestep strobe, one-cycle pulse
- state_sel  in  CW  neuron selected for readout
- state_out  out  W  membrane of neuron state_sel, combinational mux of registers
- spike_out  out  N_NEUR  spike vector of the last completed step, registered
- spike_valid  out  1  one-cycle pulse when spike_out updates
- skip_count  out  16  count of accepted zero-current samples

REQ-003 One clock; reset is synchronous and active-high, and the ports SHALL be named clk and rst.

Function
REQ-004 Per neuron, the block SHALL hold: membrane state[W], pending accumulator pend[W], refractory counter rc[4].
REQ-005 FSM states SHALL be IDLE, UPDATE, DONE; reset state IDLE.
REQ-006 in_ready SHALL be 1 in IDLE only and 0 in UPDATE and DONE.
REQ-007 An accepted nonzero sample SHALL set pend[in_ch] = min(pend[in_ch] + in_current, 2^W-1) the next cycle.
REQ-008 An accepted zero sample SHALL leave pend unchanged and increment skip_count, saturating at 0xFFFF (sparsity skip).
REQ-009 step in IDLE SHALL move to UPDATE the next cycle; a sample accepted in the same cycle as step SHALL be included in that step.
REQ-010 step in UPDATE or DONE SHALL be ignored (no queuing).
REQ-011 UPDATE SHALL visit neurons 0..N_NEUR-1 in order, one per cycle, N_NEUR cycles total.
REQ-012 Visited neuron with rc>0 SHALL get state=0, rc=rc-1, pend=0, no spike.
REQ-013 Visited neuron with rc=0 SHALL compute v = state - (state>>LEAK_SHIFT) + pend, saturating at 2^W-1, using W+1-bit intermediate.
REQ-014 If v >= THRESHOLD, the neuron SHALL spike: spike bit set, state=0, rc=REFRAC; otherwise state=v; pend=0 in both cases.
REQ-015 After the last neuron, FSM SHALL enter DONE for one cycle, during which spike_out holds the new vector and spike_valid=1; then IDLE.
REQ-016 Latency: step at cycle t SHALL yield spike_valid high at cycle t+N_NEUR+1.
REQ-017 spike_out SHALL hold its value until the next DONE; spike_valid SHALL be 0 outside DONE.
REQ-018 state_out SHALL reflect register contents with zero-cycle latency, including mid-UPDATE values.

Reset
REQ-019 rst SHALL clear all state, pend, rc, spike_out, skip_count, spike_valid to 0 and force IDLE (in_ready=1 the cycle after release).
REQ-020 rst asserted mid-UPDATE SHALL abort the step with no spike_valid pulse and all registers cleared.
REQ-021 rst SHALL take priority over in_valid and step in the same cycle.

Verification (defaults: N_NEUR=4, W=8, THRESHOLD=200, LEAK_SHIFT=1, REFRAC=2)
REQ-022 Reset: hold rst 2 cycles -> spike_out=0, skip_count=0, state_out=0 for all sel, in_ready=1.
REQ-023 Fire: inject ch0=150, ch0=60, step at t -> spike_valid at t+5, spike_out=4'b0001, state[0]=0.
REQ-024 Leak: inject ch1=100, step -> state[1]=100; step with no input -> state[1]=50; saturation: ch2=200 then ch2=200 -> pend[2]=255, step -> spike bit 2.
REQ-025 Refractory: after ch0 fire, inject ch0=250 and step twice -> no spike, state[0]=0 both times; third step with ch0=250 -> spike_out[0]=1.
REQ-026 Sparsity/handshake: three zero samples to ch3 -> skip_count=3, state[3] unchanged after step; in_valid held during UPDATE -> in_ready=0, sample not applied until IDLE.
REQ-027 Abort: assert rst at UPDATE cycle 2 -> no spike_valid, all state_out=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/sparse_lif_array.sv
// ---------------------------------------------------------------------------
// sparse_lif_array
//
// Purpose:
//   A small array of leaky integrate-and-fire neurons. Input current samples
//   arrive one at a time and are added into a per-neuron pending accumulator.
//   Zero-current samples are not added; they are only counted. A timestep
//   strobe starts a sequential sweep that visits one neuron per cycle. Each
//   visit applies leak, integrates the pending current and checks the
//   threshold, or handles the refractory period. The spike vector for the
//   whole step is published for one cycle once the sweep is finished.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous reset, active-high
//   in_valid     current sample offered
//   in_ready     sample accepted when in_valid && in_ready (IDLE only)
//   in_ch        target neuron index of the sample
//   in_current   unsigned input current
//   step         timestep strobe (one-cycle pulse), ignored while busy
//   state_sel    neuron selected for membrane readout
//   state_out    membrane of neuron state_sel (combinational read)
//   spike_out    spike vector of the last completed step (registered)
//   spike_valid  one-cycle pulse while spike_out carries a new vector
//   skip_count   saturating count of accepted zero-current samples
// ---------------------------------------------------------------------------
module sparse_lif_array #(
  parameter int N_NEUR     = 4,
  parameter int W          = 8,
  parameter int THRESHOLD  = 200,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2,
  localparam int CW        = $clog2(N_NEUR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_ch,
  input  logic [W-1:0]      in_current,
  input  logic              step,
  input  logic [CW-1:0]     state_sel,
  output logic [W-1:0]      state_out,
  output logic [N_NEUR-1:0] spike_out,
  output logic              spike_valid,
  output logic [15:0]       skip_count
);

  localparam logic [W-1:0]    THR_W    = W'(THRESHOLD);
  localparam logic [3:0]      REFRAC_W = 4'(REFRAC);
  localparam logic [CW-1:0]   LAST_IDX = CW'(N_NEUR - 1);
  localparam logic [W-1:0]    MAX_W    = '1;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } fsm_t;

  fsm_t fsm_q, fsm_d;

  logic [W-1:0]      state_q [N_NEUR];
  logic [W-1:0]      pend_q  [N_NEUR];
  logic [3:0]        rc_q    [N_NEUR];
  logic [CW-1:0]     idx_q;
  logic [N_NEUR-1:0] spike_acc_q;

  logic              accept;
  logic [W:0]        pend_sum;
  logic [W-1:0]      pend_sat;

  logic [W-1:0]      cur_state;
  logic [W-1:0]      cur_pend;
  logic [3:0]        cur_rc;
  logic [W-1:0]      leaked;
  logic [W:0]        v_wide;
  logic [W-1:0]      v_sat;
  logic              fire;
  logic [N_NEUR-1:0] fire_vec;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next-state and handshake/strobe outputs. Samples are only taken in IDLE,
  // so the sweep never races with pending-accumulator writes. A step that
  // arrives while the sweep is running is dropped, not queued.
  always_comb begin
    fsm_d       = fsm_q;
    in_ready    = 1'b0;
    spike_valid = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (step) begin
          fsm_d = UPDATE;
        end
      end
      UPDATE: begin
        if (idx_q == LAST_IDX) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        spike_valid = 1'b1;
        fsm_d       = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  assign accept = in_valid && in_ready;

  // Saturating accumulate of an incoming sample into its neuron's pending
  // current. One spare bit catches the carry.
  always_comb begin
    pend_sum = {1'b0, pend_q[in_ch]} + {1'b0, in_current};
    pend_sat = pend_sum[W] ? MAX_W : pend_sum[W-1:0];
  end

  // Membrane update for the neuron currently being visited. The leaked value
  // never exceeds the old state, so only the pending add can overflow. The
  // extra top bit of v_wide detects that overflow, and the result saturates.
  always_comb begin
    cur_state = state_q[idx_q];
    cur_pend  = pend_q[idx_q];
    cur_rc    = rc_q[idx_q];
    leaked    = cur_state - (cur_state >> LEAK_SHIFT);
    v_wide    = {1'b0, leaked} + {1'b0, cur_pend};
    v_sat     = v_wide[W] ? MAX_W : v_wide[W-1:0];
    fire      = (cur_rc == 4'd0) && (v_sat >= THR_W);
    fire_vec  = '0;
    fire_vec[idx_q] = fire;
  end

  // Neuron datapath: sample intake in IDLE, one neuron per cycle in UPDATE.
  // spike_out is loaded on the final visit so that it already holds the new
  // vector during the DONE cycle, when spike_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_NEUR; i++) begin
        state_q[i] <= '0;
        pend_q[i]  <= '0;
        rc_q[i]    <= '0;
      end
      idx_q       <= '0;
      spike_acc_q <= '0;
      spike_out   <= '0;
      skip_count  <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (accept) begin
            if (in_current != '0) begin
              pend_q[in_ch] <= pend_sat;
            end else if (skip_count != 16'hFFFF) begin
              skip_count <= skip_count + 16'd1;
            end
          end
          if (step) begin
            idx_q       <= '0;
            spike_acc_q <= '0;
          end
        end
        UPDATE: begin
          idx_q          <= idx_q + 1'b1;
          pend_q[idx_q]  <= '0;
          if (cur_rc != 4'd0) begin
            state_q[idx_q] <= '0;
            rc_q[idx_q]    <= cur_rc - 4'd1;
          end else if (fire) begin
            state_q[idx_q] <= '0;
            rc_q[idx_q]    <= REFRAC_W;
          end else begin
            state_q[idx_q] <= v_sat;
          end
          spike_acc_q <= spike_acc_q | fire_vec;
          if (idx_q == LAST_IDX) begin
            spike_out <= spike_acc_q | fire_vec;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Zero-latency readout straight from the membrane registers.
  assign state_out = state_q[state_sel];

endmodule

// File: tb/tb_sparse_lif_array.sv
// ---------------------------------------------------------------------------
// tb_sparse_lif_array
//
// Purpose:
//   Directed bench for sparse_lif_array with default parameters. The stimulus
//   process pushes the hand-computed spike vector and due cycle of every step
//   into a scoreboard queue. A monitor pops an entry on each spike_valid pulse
//   and compares it. Membrane, skip-count and handshake values are checked
//   directly against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_sparse_lif_array;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_ch;
  logic [7:0]  in_current;
  logic        step;
  logic [1:0]  state_sel;
  logic [7:0]  state_out;
  logic [3:0]  spike_out;
  logic        spike_valid;
  logic [15:0] skip_count;

  typedef struct {
    logic [3:0] vec;
    int         due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  sparse_lif_array #(
    .N_NEUR(4),
    .W(8),
    .THRESHOLD(200),
    .LEAK_SHIFT(1),
    .REFRAC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ch(in_ch),
    .in_current(in_current),
    .step(step),
    .state_sel(state_sel),
    .state_out(state_out),
    .spike_out(spike_out),
    .spike_valid(spike_valid),
    .skip_count(skip_count)
  );

  // Free-running clock and a count of rising edges seen so far.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case the stimulus ever gets stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: every spike_valid pulse must match the oldest pending entry,
  // both in vector and in the cycle it arrives.
  always @(negedge clk) begin
    if (spike_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_spike_valid: got pulse at cycle %0d, required none", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_checks++;
        if (spike_out !== e.vec) begin
          n_fail++;
          $display("[TB] FAIL spike_vector: got %b, required %b", spike_out, e.vec);
        end
        n_checks++;
        if (cyc != e.due) begin
          n_fail++;
          $display("[TB] FAIL spike_latency: got cycle %0d, required cycle %0d", cyc, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic checkState(input logic [1:0] sel, input logic [7:0] expected,
                            input string name);
    state_sel = sel;
    #1;
    checkOutput(name, 16'(state_out), 16'(expected));
  endtask

  // Offer one sample for one cycle; the DUT is expected to be in IDLE.
  task automatic applyStimulus(input logic [1:0] ch, input logic [7:0] cur);
    in_valid   = 1'b1;
    in_ch      = ch;
    in_current = cur;
    tick();
    in_valid   = 1'b0;
  endtask

  // Pulse step (optionally together with a sample) and wait until the sweep
  // has finished and the block is back in IDLE.
  task automatic issueStep(input bit with_sample, input logic [1:0] ch,
                           input logic [7:0] cur, input logic [3:0] exp_vec);
    step = 1'b1;
    if (with_sample) begin
      in_valid   = 1'b1;
      in_ch      = ch;
      in_current = cur;
    end
    sb_q.push_back('{vec: exp_vec, due: cyc + 5});
    tick();
    step     = 1'b0;
    in_valid = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_ch      = '0;
    in_current = '0;
    step       = 1'b0;
    state_sel  = '0;

    // Reset held for two cycles.
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_in_ready", 16'(in_ready), 16'd1);
    checkOutput("reset_spike_out", 16'(spike_out), 16'd0);
    checkOutput("reset_skip_count", skip_count, 16'd0);
    for (int i = 0; i < 4; i++) begin
      checkState(2'(i), 8'd0, "reset_state");
    end

    // Fire: 150 + 60 = 210 crosses 200.
    applyStimulus(2'd0, 8'd150);
    applyStimulus(2'd0, 8'd60);
    issueStep(1'b0, 2'd0, 8'd0, 4'b0001);
    checkState(2'd0, 8'd0, "fire_state0");

    // Leak: a sample issued together with step is part of that step.
    issueStep(1'b1, 2'd1, 8'd100, 4'b0000);
    checkState(2'd1, 8'd100, "leak_state1_first");
    issueStep(1'b0, 2'd0, 8'd0, 4'b0000);
    checkState(2'd1, 8'd50, "leak_state1_second");

    // Saturation: 200 + 200 clamps to 255 and fires neuron 2.
    applyStimulus(2'd2, 8'd200);
    applyStimulus(2'd2, 8'd200);
    issueStep(1'b0, 2'd0, 8'd0, 4'b0100);
    checkState(2'd2, 8'd0, "sat_state2");
    checkState(2'd1, 8'd25, "sat_state1_leak");

    // Refractory: fire, two blocked steps, then fire again.
    applyStimulus(2'd0, 8'd250);
    issueStep(1'b0, 2'd0, 8'd0, 4'b0001);
    applyStimulus(2'd0, 8'd250);
    issueStep(1'b0, 2'd0, 8'd0, 4'b0000);
    checkState(2'd0, 8'd0, "refrac_state0_first");
    applyStimulus(2'd0, 8'd250);
    issueStep(1'b0, 2'd0, 8'd0, 4'b0000);
    checkState(2'd0, 8'd0, "refrac_state0_second");
    applyStimulus(2'd0, 8'd250);
    issueStep(1'b0, 2'd0, 8'd0, 4'b0001);
    checkState(2'd1, 8'd2, "refrac_state1_leak");

    // Sparsity: zero samples are counted and not integrated.
    applyStimulus(2'd3, 8'd40);
    issueStep(1'b0, 2'd0, 8'd0, 4'b0000);
    checkState(2'd3, 8'd40, "sparse_state3_before");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'd3, 8'd0);
    end
    checkOutput("sparse_skip_count", skip_count, 16'd3);
    issueStep(1'b0, 2'd0, 8'd0, 4'b0000);
    checkState(2'd3, 8'd20, "sparse_state3_after");

    // Handshake: in_valid held through the sweep must wait for IDLE. Also
    // reads neuron 3 mid-sweep, before and after it is visited.
    state_sel = 2'd3;
    step = 1'b1;
    sb_q.push_back('{vec: 4'b0000, due: cyc + 5});
    tick();
    step       = 1'b0;
    in_valid   = 1'b1;
    in_ch      = 2'd1;
    in_current = 8'd100;
    for (int k = 0; k < 5; k++) begin
      checkOutput("busy_in_ready", 16'(in_ready), 16'd0);
      if (k == 3) checkOutput("mid_update_state3_old", 16'(state_out), 16'd20);
      if (k == 4) checkOutput("mid_update_state3_new", 16'(state_out), 16'd10);
      tick();
    end
    checkOutput("idle_in_ready", 16'(in_ready), 16'd1);
    checkState(2'd1, 8'd1, "held_sample_not_applied");
    tick();
    in_valid = 1'b0;
    issueStep(1'b0, 2'd0, 8'd0, 4'b0000);
    checkState(2'd1, 8'd101, "held_sample_applied");

    // Abort: reset on the second sweep cycle suppresses the pulse and clears
    // everything, including the pending 250 on neuron 2.
    applyStimulus(2'd2, 8'd250);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checkOutput("abort_in_ready", 16'(in_ready), 16'd1);
    checkOutput("abort_spike_out", 16'(spike_out), 16'd0);
    checkOutput("abort_skip_count", skip_count, 16'd0);
    for (int i = 0; i < 4; i++) begin
      checkState(2'(i), 8'd0, "abort_state");
    end
    repeat (4) tick();
    issueStep(1'b0, 2'd0, 8'd0, 4'b0000);
    checkState(2'd2, 8'd0, "abort_pend_cleared");

    // Any step whose pulse never arrived is still queued.
    repeat (3) tick();
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      n_fail++;
      $display("[TB] FAIL missing_spike_valid: got none, required pulse at cycle %0d", e.due);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
